mul_div_unit: RTL and testbench

//  Multi-cycle multiply/divide unit with architectural HI/LO registers, beside the execute-stage ALU.

---
 rtl/mul_div_unit_if.sv | 40 ++++
 rtl/mul_div_unit.sv | 198 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// -----------------------------------------------------------------------------
// mul_div_unit_if
//   Bundles the issue and result signals between the register-read/writeback
//   stages and the multi-cycle multiply/divide unit.
//
//   w_start      issue request, qualified by w_op_code_6
//   w_op_code_6  SPECIAL_* opcode (MULT/MULTU/DIV/DIVU/MFHI/MFLO)
//   w_input1_x   rs operand: multiplicand / dividend
//   w_input2_x   rt operand: multiplier / divisor
//   w_busy       operation in flight, pipeline stall request
//   w_done       one-cycle pulse when HI/LO are updated
//   w_hi_x       HI register
//   w_lo_x       LO register
//   w_output_x   MFHI/MFLO read data
//
//   master: issuing pipeline side, slave: the unit itself.
// -----------------------------------------------------------------------------
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             w_start;
  logic [5:0]       w_op_code_6;
  logic [WIDTH-1:0] w_input1_x;
  logic [WIDTH-1:0] w_input2_x;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_hi_x;
  logic [WIDTH-1:0] w_lo_x;
  logic [WIDTH-1:0] w_output_x;

  modport master (
    output w_start, w_op_code_6, w_input1_x, w_input2_x,
    input  w_busy, w_done, w_hi_x, w_lo_x, w_output_x
  );

  modport slave (
    input  w_start, w_op_code_6, w_input1_x, w_input2_x,
    output w_busy, w_done, w_hi_x, w_lo_x, w_output_x
  );
endinterface

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Multi-cycle multiply/divide unit holding the architectural HI/LO
//   registers. MULT/MULTU use shift-add, DIV/DIVU use restoring division,
//   one bit per cycle. Results land in HI/LO WIDTH+1 cycles after issue.
//   MFHI/MFLO are served combinationally from HI/LO.
//
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset, aborts any operation in flight
//   bus      mul_div_unit_if slave: issue operands in, busy/done/HI/LO/read
//            data out
// -----------------------------------------------------------------------------
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  mul_div_unit_if.slave bus
);

  localparam logic [5:0] SPECIAL_MFHI  = 6'h10;
  localparam logic [5:0] SPECIAL_MFLO  = 6'h12;
  localparam logic [5:0] SPECIAL_MULT  = 6'h18;
  localparam logic [5:0] SPECIAL_MULTU = 6'h19;
  localparam logic [5:0] SPECIAL_DIV   = 6'h1a;
  localparam logic [5:0] SPECIAL_DIVU  = 6'h1b;

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   op_hold;
  logic [WIDTH-1:0]   raw_a;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               neg_lo;
  logic               neg_hi;
  logic               div_zero;
  logic               is_div;
  logic               done_q;

  logic               issue_ok;
  logic               is_mul_op;
  logic               is_div_op;
  logic               is_signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  // Opcode decode and operand magnitudes. Unsigned ops never flag a sign,
  // so their operands pass through untouched.
  always_comb begin
    is_mul_op    = (bus.w_op_code_6 == SPECIAL_MULT) || (bus.w_op_code_6 == SPECIAL_MULTU);
    is_div_op    = (bus.w_op_code_6 == SPECIAL_DIV)  || (bus.w_op_code_6 == SPECIAL_DIVU);
    is_signed_op = (bus.w_op_code_6 == SPECIAL_MULT) || (bus.w_op_code_6 == SPECIAL_DIV);
    a_neg        = is_signed_op & bus.w_input1_x[WIDTH-1];
    b_neg        = is_signed_op & bus.w_input2_x[WIDTH-1];
    a_mag        = a_neg ? -bus.w_input1_x : bus.w_input1_x;
    b_mag        = b_neg ? -bus.w_input2_x : bus.w_input2_x;
  end

  // Per-iteration arithmetic. The multiplier sits in the low half of acc and
  // is consumed LSB-first; the dividend sits in the low half and is shifted
  // into the partial remainder MSB-first. The extra bit holds the carry of
  // the add or the borrow of the trial subtract.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_hold} : {(WIDTH+1){1'b0}});
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, op_hold};
    product   = neg_lo ? -acc : acc;
    quot      = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem       = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // State register; reset drops any operation in flight at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Starts are only taken in IDLE, so a start that
  // coincides with FIX or arrives while busy is simply not seen.
  always_comb begin
    next_state = state;
    issue_ok   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.w_start && (is_mul_op || is_div_op)) begin
          issue_ok   = 1'b1;
          next_state = is_mul_op ? ST_MUL : ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        if (count == CW'(1)) begin
          next_state = ST_FIX;
        end
      end
      ST_FIX:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath: operand latch on issue, one iteration per MUL/DIV cycle, and
  // sign fix-up plus HI/LO write in FIX. Divide by zero bypasses the
  // iteration result so HI returns the raw dividend.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      acc      <= '0;
      op_hold  <= '0;
      raw_a    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == ST_FIX);
      case (state)
        ST_IDLE: begin
          if (issue_ok) begin
            count    <= CW'(WIDTH);
            acc      <= {{WIDTH{1'b0}}, (is_mul_op ? b_mag : a_mag)};
            op_hold  <= is_mul_op ? a_mag : b_mag;
            raw_a    <= bus.w_input1_x;
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= a_neg;
            div_zero <= is_div_op && (bus.w_input2_x == '0);
            is_div   <= is_div_op;
          end
        end
        ST_MUL: begin
          acc   <= {mul_sum, acc[WIDTH-1:1]};
          count <= count - CW'(1);
        end
        ST_DIV: begin
          if (div_trial[WIDTH]) begin
            acc <= {acc[2*WIDTH-2:0], 1'b0};
          end else begin
            acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          end
          count <= count - CW'(1);
        end
        ST_FIX: begin
          if (is_div) begin
            if (div_zero) begin
              hi_q <= raw_a;
              lo_q <= '1;
            end else begin
              hi_q <= rem;
              lo_q <= quot;
            end
          end else begin
            hi_q <= product[2*WIDTH-1:WIDTH];
            lo_q <= product[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Status and read port. While busy, MFHI/MFLO still see the last
  // completed result; the pipeline is stalled on w_busy anyway.
  always_comb begin
    bus.w_busy = (state != ST_IDLE);
    bus.w_done = done_q;
    bus.w_hi_x = hi_q;
    bus.w_lo_x = lo_q;
    if (bus.w_op_code_6 == SPECIAL_MFHI) begin
      bus.w_output_x = hi_q;
    end else if (bus.w_op_code_6 == SPECIAL_MFLO) begin
      bus.w_output_x = lo_q;
    end else begin
      bus.w_output_x = '0;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//   Scoreboard bench for mul_div_unit: expected {HI,LO} values come from a
//   behavioural model and are queued at issue, then popped and compared when
//   w_done pulses.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

  localparam logic [5:0] SPECIAL_MFHI  = 6'h10;
  localparam logic [5:0] SPECIAL_MFLO  = 6'h12;
  localparam logic [5:0] SPECIAL_MULT  = 6'h18;
  localparam logic [5:0] SPECIAL_MULTU = 6'h19;
  localparam logic [5:0] SPECIAL_DIV   = 6'h1a;
  localparam logic [5:0] SPECIAL_DIVU  = 6'h1b;
  localparam logic [5:0] SPECIAL_ADD   = 6'h20;

  logic clock;
  logic reset_n;

  int total;
  int bad;
  int cycle_cnt;
  int issue_cyc;

  logic [63:0] exp_q[$];
  logic [63:0] last_hilo;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Rising-edge count, used to measure issue-to-done latency.
  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  // Behavioural reference: native wide arithmetic, not bit iteration.
  function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sp;
    logic signed [31:0] qa;
    logic signed [31:0] qb;
    logic [31:0]        q;
    logic [31:0]        r;
    case (op)
      SPECIAL_MULTU: return {32'd0, a} * {32'd0, b};
      SPECIAL_MULT: begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sp = sa * sb;
        return sp;
      end
      SPECIAL_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      SPECIAL_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        qa = a;
        qb = b;
        q  = qa / qb;
        r  = qa % qb;
        return {r, q};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one issue cycle; optionally queue its expected result.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit push);
    @(negedge clock);
    bus.w_start     = 1'b1;
    bus.w_op_code_6 = op;
    bus.w_input1_x  = a;
    bus.w_input2_x  = b;
    if (push) exp_q.push_back(model(op, a, b));
    @(negedge clock);
    issue_cyc   = cycle_cnt;
    bus.w_start = 1'b0;
    checkOutput("busy_after_issue", {63'd0, bus.w_busy}, 64'd1);
  endtask

  // Bounded wait for w_done, then latency, HI/LO and pulse-width checks.
  task automatic waitDone(input string tag);
    logic [63:0] exp;
    while (!bus.w_done && (cycle_cnt - issue_cyc) < 45) @(negedge clock);
    if (!bus.w_done) begin
      checkOutput({tag, "_timeout"}, {63'd0, bus.w_done}, 64'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    checkOutput({tag, "_latency"}, 64'(cycle_cnt - issue_cyc), 64'd33);
    checkOutput({tag, "_busy_at_done"}, {63'd0, bus.w_busy}, 64'd0);
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd1);
      return;
    end
    exp       = exp_q.pop_front();
    last_hilo = exp;
    checkOutput({tag, "_hilo"}, {bus.w_hi_x, bus.w_lo_x}, exp);
    @(negedge clock);
    checkOutput({tag, "_done_pulse"}, {63'd0, bus.w_done}, 64'd0);
  endtask

  task automatic checkRead(input string tag, input logic [5:0] op, input logic [31:0] exp);
    bus.w_op_code_6 = op;
    #1;
    checkOutput(tag, {32'd0, bus.w_output_x}, {32'd0, exp});
  endtask

  initial begin
    int extra;
    logic [5:0] ops [4];
    ops[0] = SPECIAL_MULT;
    ops[1] = SPECIAL_MULTU;
    ops[2] = SPECIAL_DIV;
    ops[3] = SPECIAL_DIVU;

    total           = 0;
    bad             = 0;
    cycle_cnt       = 0;
    issue_cyc       = 0;
    last_hilo       = 64'd0;
    bus.w_start     = 1'b0;
    bus.w_op_code_6 = 6'd0;
    bus.w_input1_x  = 32'd0;
    bus.w_input2_x  = 32'd0;
    reset_n         = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_busy", {63'd0, bus.w_busy}, 64'd0);
    checkOutput("reset_done", {63'd0, bus.w_done}, 64'd0);
    checkOutput("reset_hilo", {bus.w_hi_x, bus.w_lo_x}, 64'd0);
    reset_n = 1'b1;

    $display("[TB] directed operations");
    applyStimulus(SPECIAL_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    waitDone("multu_max");
    applyStimulus(SPECIAL_MULT, -32'sd3, 32'd7, 1'b1);
    waitDone("mult_neg");
    checkRead("mfhi", SPECIAL_MFHI, 32'hFFFF_FFFF);
    checkRead("mflo", SPECIAL_MFLO, 32'hFFFF_FFEB);
    checkRead("other_op_zero", SPECIAL_ADD, 32'd0);
    applyStimulus(SPECIAL_DIV, -32'sd7, 32'd2, 1'b1);
    waitDone("div_neg");
    applyStimulus(SPECIAL_DIVU, 32'd100, 32'd7, 1'b1);
    waitDone("divu");
    applyStimulus(SPECIAL_DIV, 32'd5, 32'd0, 1'b1);
    waitDone("div_by_zero");
    applyStimulus(SPECIAL_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    waitDone("div_overflow");

    $display("[TB] start while busy");
    applyStimulus(SPECIAL_MULT, 32'h1234_5678, -32'sd99, 1'b1);
    repeat (8) @(negedge clock);
    checkRead("mflo_while_busy", SPECIAL_MFLO, last_hilo[31:0]);
    bus.w_start     = 1'b1;
    bus.w_op_code_6 = SPECIAL_DIVU;
    bus.w_input1_x  = 32'd100;
    bus.w_input2_x  = 32'd7;
    @(negedge clock);
    bus.w_start = 1'b0;
    checkOutput("busy_after_ignored", {63'd0, bus.w_busy}, 64'd1);
    waitDone("mult_ignore");
    extra = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.w_done) extra++;
    end
    checkOutput("no_second_done", 64'(extra), 64'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(SPECIAL_DIV, 32'd1000, 32'd3, 1'b0);
    repeat (14) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_busy", {63'd0, bus.w_busy}, 64'd0);
    checkOutput("abort_hilo", {bus.w_hi_x, bus.w_lo_x}, 64'd0);
    checkOutput("abort_done", {63'd0, bus.w_done}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    extra   = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.w_done) extra++;
    end
    checkOutput("abort_no_done", 64'(extra), 64'd0);
    applyStimulus(SPECIAL_MULTU, 32'd6, 32'd7, 1'b1);
    waitDone("multu_after_reset");

    $display("[TB] random operations");
    for (int i = 0; i < 6; i++) begin
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = ops[$urandom_range(0, 3)];
      a  = $urandom;
      b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 3 == 2) b = -b;
      applyStimulus(op, a, b, 1'b1);
      waitDone("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
